fadd_core: RTL and testbench

- Back end of the FPU adder-subtractor. Consumes the selected operand bundle (signs, magnitude comparison, common exponent, aligned 28-bit mantissas) from the normal/subnormal select stage.
- Performs the effective add or subtract, then normalizes, rounds (RNE) and packs to IEEE-754 single precision.
- Multi-cycle FSM with valid/ready handshakes on input and output. Sits between the operand-select stage and the FPU result writeback.

---
 rtl/fadd_core.sv | 138 +++++++++++++
 tb/tb_fadd_core.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fadd_core.sv
// FPU adder back end: effective add/sub, normalize, RNE round, pack to binary32.
// Define FADD_FLAGS_EN to add the {overflow, underflow, inexact} flags port.
module fadd_core #(
  parameter int EW = 8,
  parameter int MW = 28
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          S_A,
  input  logic          S_B,
  input  logic          C,
  input  logic [EW-1:0] E,
  input  logic [MW-1:0] M_A,
  input  logic [MW-1:0] M_B,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_result
`ifdef FADD_FLAGS_EN
  ,
  output logic [2:0]    flags
`endif
);

  localparam int XW = EW + 2;
  localparam int FW = MW - 5;

  typedef enum logic [2:0] {ST_IDLE, ST_ADD, ST_NORM, ST_ROUND, ST_DONE} state_t;

  state_t        r_state;
  logic          r_sa, r_sb, r_c, r_sign;
  logic [MW-1:0] r_ma, r_mb, r_m;
  logic [XW-1:0] r_exp;
  logic          r_in_ready, r_valid;
  logic [31:0]   r_result;
`ifdef FADD_FLAGS_EN
  logic [2:0]    r_flags;
`endif

  logic          w_eff_sub, w_sign;
  logic [MW-1:0] w_mag;
  logic          w_inc, w_carry, w_hid, w_inf, w_inexact;
  logic [MW-4:0] w_rsum;
  logic [XW-1:0] w_efin;
  logic [EW-1:0] w_expf;
  logic [FW-1:0] w_frac;
  logic [31:0]   w_packed;

  always_comb begin
    w_eff_sub = r_sa ^ r_sb;
    w_mag     = r_ma + r_mb;
    w_sign    = r_sa;
    if (w_eff_sub) begin
      w_mag  = r_c ? (r_ma - r_mb) : (r_mb - r_ma);
      w_sign = r_c ? r_sa : r_sb;
    end
  end

  // Rounding works on m[27:3] so the carry out lands in the top bit of w_rsum.
  always_comb begin
    w_inexact = r_m[2] | r_m[1] | r_m[0];
    w_inc     = r_m[2] & (r_m[1] | r_m[0] | r_m[3]);
    w_rsum    = r_m[MW-1:3] + (MW-3)'(w_inc);
    w_carry   = w_rsum[MW-4];
    w_efin    = r_exp + XW'(w_carry);
    w_hid     = w_carry | w_rsum[MW-5];
    w_inf     = (w_efin >= XW'({EW{1'b1}}));
    w_expf    = w_inf ? '1 : (w_hid ? w_efin[EW-1:0] : '0);
    w_frac    = (w_inf | w_carry) ? '0 : w_rsum[MW-6:0];
    w_packed  = {r_sign, w_expf, w_frac};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_in_ready <= 1'b1;
      r_valid    <= 1'b0;
      r_result   <= '0;
`ifdef FADD_FLAGS_EN
      r_flags    <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: if (in_valid) begin
          r_sa       <= S_A;
          r_sb       <= S_B;
          r_c        <= C;
          r_exp      <= XW'(E);
          r_ma       <= M_A;
          r_mb       <= M_B;
          r_in_ready <= 1'b0;
          r_state    <= ST_ADD;
        end
        ST_ADD: begin
          r_m     <= w_mag;
          r_sign  <= (w_mag == '0) ? 1'b0 : w_sign;
          r_state <= ST_NORM;
        end
        ST_NORM: begin
          if (r_m == '0) begin
            r_state <= ST_ROUND;
          end else if (r_m[MW-1]) begin
            r_m   <= {1'b0, r_m[MW-1:2], r_m[1] | r_m[0]};
            r_exp <= r_exp + XW'(1);
          end else if (!r_m[MW-2] && (r_exp > XW'(1))) begin
            r_m   <= r_m << 1;
            r_exp <= r_exp - XW'(1);
          end else begin
            r_state <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          r_result <= w_packed;
`ifdef FADD_FLAGS_EN
          r_flags  <= {w_inf, ~w_inf & ~w_hid & w_inexact, w_inexact};
`endif
          r_valid  <= 1'b1;
          r_state  <= ST_DONE;
        end
        ST_DONE: if (out_ready) begin
          r_valid    <= 1'b0;
          r_in_ready <= 1'b1;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_valid;
  assign out_result = r_result;
`ifdef FADD_FLAGS_EN
  assign flags      = r_flags;
`endif

endmodule

// File: tb/tb_fadd_core.sv
// Self-checking bench for fadd_core: scoreboard of expected results and latencies.
module tb_fadd_core;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, S_A, S_B, C, out_valid, out_ready;
  logic [7:0]  E;
  logic [27:0] M_A, M_B;
  logic [31:0] out_result;
`ifdef FADD_FLAGS_EN
  logic [2:0]  flags;
`endif

  always #5 clk = ~clk;

  fadd_core #(.EW(8), .MW(28)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .S_A(S_A), .S_B(S_B), .C(C), .E(E), .M_A(M_A), .M_B(M_B),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
`ifdef FADD_FLAGS_EN
    , .flags(flags)
`endif
  );

  typedef struct {
    logic        sa, sb, c;
    logic [7:0]  e;
    logic [27:0] ma, mb;
    logic [31:0] res;
    int unsigned n;
    logic [2:0]  fl;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    int unsigned lat;
    logic [2:0]  fl;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic sa, input logic sb, input logic c, input logic [7:0] e,
                              input logic [27:0] ma, input logic [27:0] mb, input logic [31:0] res,
                              input int unsigned n, input logic [2:0] fl);
    vec_t v;
    v.sa = sa; v.sb = sb; v.c = c; v.e = e; v.ma = ma; v.mb = mb;
    v.res = res; v.n = n; v.fl = fl;
    return v;
  endfunction

  // Stimulus only: queue the expectation, present the bundle, return just after the accept edge.
  task automatic drive_op(input vec_t v);
    exp_t x;
    int unsigned w = 0;
    x.res = v.res; x.lat = 3 + v.n; x.fl = v.fl;
    sb_q.push_back(x);
    S_A = v.sa; S_B = v.sb; C = v.c; E = v.e; M_A = v.ma; M_B = v.mb;
    in_valid = 1'b1;
    while (!in_ready && w < 60) begin
      @(posedge clk); #1;
      w++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Edges from the accept edge until out_valid is seen; 100 means it never came.
  task automatic wait_out(output int unsigned cnt);
    cnt = 0;
    while (!out_valid && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    S_A = 0; S_B = 0; C = 0; E = '0; M_A = '0; M_B = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (out_result !== 32'h0) begin errors++; $display("FAIL reset_out_result got %h want 0", out_result); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_table(input string name, input vec_t v[]);
    int unsigned lat;
    exp_t x;
    foreach (v[i]) begin
      drive_op(v[i]);
      wait_out(lat);
      x = sb_q.pop_front();
      checks++;
      if (lat !== x.lat) begin
        errors++; $display("FAIL %s[%0d]_latency got %0d want %0d", name, i, lat, x.lat);
      end
      checks++;
      if (out_result !== x.res) begin
        errors++; $display("FAIL %s[%0d]_result got %h want %h", name, i, out_result, x.res);
      end
`ifdef FADD_FLAGS_EN
      checks++;
      if (flags !== x.fl) begin
        errors++; $display("FAIL %s[%0d]_flags got %b want %b", name, i, flags, x.fl);
      end
`endif
      @(posedge clk); #1;
    end
  endtask

  task automatic test_arith;
    vec_t v[] = new[6];
    v[0] = mk(0, 0, 1, 8'd127, 28'h4000000, 28'h4000000, 32'h40000000, 1, 3'b000);
    v[1] = mk(0, 1, 1, 8'd127, 28'h4000000, 28'h4000000, 32'h00000000, 0, 3'b000);
    v[2] = mk(0, 1, 1, 8'd127, 28'h4000000, 28'h2000000, 32'h3F000000, 1, 3'b000);
    v[3] = mk(0, 1, 0, 8'd127, 28'h2000000, 28'h4000000, 32'hBF000000, 1, 3'b000);
    v[4] = mk(1, 0, 0, 8'd127, 28'h2000000, 28'h4000000, 32'h3F000000, 1, 3'b000);
    v[5] = mk(0, 1, 1, 8'd127, 28'h4000000, 28'h3FFFFF8, 32'h34000000, 23, 3'b000);
    run_table("arith", v);
  endtask

  task automatic test_rne;
    vec_t v[] = new[3];
    v[0] = mk(0, 0, 1, 8'd127, 28'h4000000, 28'h0000004, 32'h3F800000, 0, 3'b001);
    v[1] = mk(0, 0, 1, 8'd127, 28'h4000000, 28'h000000C, 32'h3F800002, 0, 3'b001);
    v[2] = mk(0, 0, 1, 8'd127, 28'h4000000, 28'h3FFFFFC, 32'h40000000, 0, 3'b001);
    run_table("rne", v);
  endtask

  task automatic test_range;
    vec_t v[] = new[3];
    v[0] = mk(0, 0, 1, 8'd254, 28'h7FFFFF8, 28'h7FFFFF8, 32'h7F800000, 1, 3'b100);
    v[1] = mk(0, 0, 1, 8'd1,   28'h0000008, 28'h0000000, 32'h00000001, 0, 3'b000);
    v[2] = mk(0, 0, 1, 8'd1,   28'h0000004, 28'h0000000, 32'h00000000, 0, 3'b011);
    run_table("range", v);
  endtask

  task automatic test_backpressure;
    int unsigned lat;
    exp_t x;
    out_ready = 1'b0;
    drive_op(mk(0, 0, 1, 8'd127, 28'h4000000, 28'h4000000, 32'h40000000, 1, 3'b000));
    wait_out(lat);
    x = sb_q.pop_front();
    checks++;
    if (lat !== x.lat) begin errors++; $display("FAIL bp_latency got %0d want %0d", lat, x.lat); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_result !== x.res || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d] got valid=%b result=%h in_ready=%b want 1 %h 0",
                 k, out_valid, out_result, in_ready, x.res);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_norm;
    bit seen = 0;
    drive_op(mk(0, 1, 1, 8'd127, 28'h4000000, 28'h3FFFFF8, 32'h34000000, 23, 3'b000));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 32'h0) begin
      errors++;
      $display("FAIL rst_norm got in_ready=%b valid=%b result=%h want 1 0 0", in_ready, out_valid, out_result);
    end
    for (int k = 0; k < 40; k++) begin
      if (out_valid) seen = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rst_discard got out_valid=1 want 0"); end
  endtask

  task automatic test_back_to_back;
    vec_t v[] = new[2];
    v[0] = mk(0, 0, 1, 8'd127, 28'h4000000, 28'h4000000, 32'h40000000, 1, 3'b000);
    v[1] = mk(0, 1, 1, 8'd127, 28'h4000000, 28'h2000000, 32'h3F000000, 1, 3'b000);
    run_table("b2b", v);
  endtask

  initial begin
    test_reset;
    test_arith;
    test_rne;
    test_range;
    test_backpressure;
    test_reset_mid_norm;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
